// File: rtl/cfg_afu_reset_seq.sv
// cfg_afu_reset_seq
// -----------------
// Sequences function-level and AFU-control-level resets for config function 1.
// It sits between the cfg_func1 register file and the AFU. A reset request
// fences the AFU and waits for it to quiesce, with a bounded wait. It then
// holds the AFU in reset for the advertised duration, releases it, lets it
// settle, and finally reports completion and clears the serviced pending bits.
//
// Request/status protocol: each *_req input is a single-cycle strobe with no
// back-pressure. The strobe sets its pending bit on the next edge, in any
// state. The pending bit is the status that software reads back. A request
// that arrives while its bit is already pending is absorbed.
//
// Ports:
//   clock                        sole clock
//   reset_n                      async active-low reset
//   f1_ro_ofunc_reset_duration   function reset duration, in ticks (static)
//   f1_ro_octrl00_reset_duration AFU-control reset duration, in ticks (static)
//   cfg_ofunc_func_reset_req     1-cycle pulse, function reset written
//   cfg_octrl00_afu_reset_req    1-cycle pulse, AFU control reset written
//   afu_cfg_quiesced             level, AFU has no outstanding commands
//   cfg_err_clear                pulse, clears sticky timeout flag
//   cfg_afu_fence                block new AFU commands
//   cfg_afu_reset                active-high reset to AFU
//   cfg_ofunc_reset_pending      function reset in progress
//   cfg_octrl00_reset_pending    control reset in progress
//   cfg_reset_done               1-cycle pulse at sequence completion
//   cfg_quiesce_timeout          sticky error flag
//
// All outputs come straight from flops. No input reaches an output
// combinationally.

module cfg_afu_reset_seq #(
    parameter int TICK_CYCLES     = 256,   // clocks per duration unit, 2..65535
    parameter int QUIESCE_TIMEOUT = 4096,  // max cycles in FENCE
    parameter int SETTLE_CYCLES   = 16     // cycles after release before done, >= 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] f1_ro_ofunc_reset_duration,
    input  logic [7:0] f1_ro_octrl00_reset_duration,
    input  logic       cfg_ofunc_func_reset_req,
    input  logic       cfg_octrl00_afu_reset_req,
    input  logic       afu_cfg_quiesced,
    input  logic       cfg_err_clear,
    output logic       cfg_afu_fence,
    output logic       cfg_afu_reset,
    output logic       cfg_ofunc_reset_pending,
    output logic       cfg_octrl00_reset_pending,
    output logic       cfg_reset_done,
    output logic       cfg_quiesce_timeout
);

    localparam int TW  = $clog2(TICK_CYCLES);
    localparam int TOW = $clog2(QUIESCE_TIMEOUT + 1);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST     = TOW'(QUIESCE_TIMEOUT - 1);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FENCE   = 3'd1,
        S_RESET   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t         state_q;
    logic           fence_q;
    logic           afu_reset_q;
    logic           done_q;
    logic           timeout_q;
    logic           func_pend_q;
    logic           ctrl_pend_q;
    logic           svc_func_q;     // current sequence is a function reset
    logic [TW-1:0]  tick_cnt_q;
    logic [7:0]     dur_cnt_q;
    logic [TOW-1:0] to_cnt_q;
    logic [SW-1:0]  settle_cnt_q;

    logic           func_pend_d;
    logic           ctrl_pend_d;
    logic           timeout_d;
    logic           enter_done;
    logic           timeout_hit;
    logic [7:0]     dur_sel;
    logic [7:0]     dur_load;

    always_comb begin
        enter_done  = 1'b0;
        timeout_hit = 1'b0;
        dur_sel     = 8'd0;
        dur_load    = 8'd0;
        func_pend_d = 1'b0;
        ctrl_pend_d = 1'b0;
        timeout_d   = 1'b0;

        // Pending bits are cleared on the edge that enters DONE, so they drop
        // in the same cycle that cfg_reset_done is high.
        enter_done  = (state_q == S_RELEASE) && (settle_cnt_q == SETTLE_LAST);
        timeout_hit = (state_q == S_FENCE) && !afu_cfg_quiesced && (to_cnt_q == TO_LAST);

        // The function duration wins whenever a function reset is pending at
        // the moment the sequence leaves FENCE.
        dur_sel  = func_pend_q ? f1_ro_ofunc_reset_duration : f1_ro_octrl00_reset_duration;
        dur_load = (dur_sel == 8'd0) ? 8'd1 : dur_sel;

        // A function sequence also services any control request. A control-only
        // sequence leaves a late function request pending, which starts a
        // fresh sequence. A new strobe on the clearing edge still sets the bit.
        func_pend_d = cfg_ofunc_func_reset_req  | (func_pend_q & ~(enter_done & svc_func_q));
        ctrl_pend_d = cfg_octrl00_afu_reset_req | (ctrl_pend_q & ~enter_done);

        // When a clear and a new timeout land on the same edge, the set wins.
        timeout_d = timeout_hit | (timeout_q & ~cfg_err_clear);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            func_pend_q <= 1'b0;
            ctrl_pend_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            func_pend_q <= func_pend_d;
            ctrl_pend_q <= ctrl_pend_d;
            timeout_q   <= timeout_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            fence_q      <= 1'b0;
            afu_reset_q  <= 1'b0;
            done_q       <= 1'b0;
            svc_func_q   <= 1'b0;
            tick_cnt_q   <= '0;
            dur_cnt_q    <= 8'd0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (func_pend_q || ctrl_pend_q) begin
                        state_q  <= S_FENCE;
                        fence_q  <= 1'b1;
                        to_cnt_q <= '0;
                    end
                end

                S_FENCE: begin
                    // Proceed on quiesce, or give up waiting after the
                    // timeout. The sticky flag is raised by timeout_hit.
                    if (afu_cfg_quiesced || (to_cnt_q == TO_LAST)) begin
                        state_q     <= S_RESET;
                        afu_reset_q <= 1'b1;
                        tick_cnt_q  <= '0;
                        dur_cnt_q   <= dur_load;
                        svc_func_q  <= func_pend_q;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_RESET: begin
                    // Reset is held for dur_load * TICK_CYCLES cycles. The
                    // exit edge is the last prescaler tick of the last unit.
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        if (dur_cnt_q == 8'd1) begin
                            state_q      <= S_RELEASE;
                            afu_reset_q  <= 1'b0;
                            settle_cnt_q <= '0;
                        end else begin
                            dur_cnt_q <= dur_cnt_q - 8'd1;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    // The fence drops here. Any pending work left over is
                    // picked up from IDLE.
                    state_q <= S_IDLE;
                    fence_q <= 1'b0;
                end

                default: begin
                    state_q     <= S_IDLE;
                    fence_q     <= 1'b0;
                    afu_reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_afu_fence             = fence_q;
    assign cfg_afu_reset             = afu_reset_q;
    assign cfg_ofunc_reset_pending   = func_pend_q;
    assign cfg_octrl00_reset_pending = ctrl_pend_q;
    assign cfg_reset_done            = done_q;
    assign cfg_quiesce_timeout       = timeout_q;

endmodule

// File: tb/tb_cfg_afu_reset_seq.sv
// Directed bench for cfg_afu_reset_seq with TICK_CYCLES=4,
// QUIESCE_TIMEOUT=8 and SETTLE_CYCLES=2. Inputs change and outputs are
// sampled 1 time unit after each rising edge.

module tb_cfg_afu_reset_seq;

    logic       clock;
    logic       reset_n;
    logic [7:0] ofunc_dur;
    logic [7:0] octrl_dur;
    logic       func_req;
    logic       ctrl_req;
    logic       quiesced;
    logic       err_clear;
    logic       fence;
    logic       afu_reset;
    logic       func_pend;
    logic       ctrl_pend;
    logic       done;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int n;
    int dn;

    cfg_afu_reset_seq #(
        .TICK_CYCLES    (4),
        .QUIESCE_TIMEOUT(8),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .f1_ro_ofunc_reset_duration   (ofunc_dur),
        .f1_ro_octrl00_reset_duration (octrl_dur),
        .cfg_ofunc_func_reset_req     (func_req),
        .cfg_octrl00_afu_reset_req    (ctrl_req),
        .afu_cfg_quiesced             (quiesced),
        .cfg_err_clear                (err_clear),
        .cfg_afu_fence                (fence),
        .cfg_afu_reset                (afu_reset),
        .cfg_ofunc_reset_pending      (func_pend),
        .cfg_octrl00_reset_pending    (ctrl_pend),
        .cfg_reset_done               (done),
        .cfg_quiesce_timeout          (timeout)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts the cycles for which cfg_afu_reset stays high, starting now.
    task automatic count_reset(output int len);
        len = 0;
        while (afu_reset === 1'b1 && len < 200) begin
            len++;
            tick();
        end
    endtask

    // Waits for the done pulse (bounded) and checks that it appeared.
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check(tag, done, 1);
    endtask

    // Runs after a request has been latched with quiesced=1. It checks fence
    // and reset timing, the reset length, the done pulse and the clearing of
    // both pending bits.
    task automatic run_quiesced_seq(input string p, input int exp_len);
        int len;
        check({p, "_fence_pre"}, fence, 0);
        tick();
        check({p, "_fence"}, fence, 1);
        check({p, "_rst_pre"}, afu_reset, 0);
        tick();
        check({p, "_rst_on"}, afu_reset, 1);
        count_reset(len);
        check({p, "_rst_len"}, len, exp_len);
        check({p, "_fence_rel"}, fence, 1);
        tick();
        check({p, "_done_early"}, done, 0);
        tick();
        check({p, "_done"}, done, 1);
        check({p, "_func_clr"}, func_pend, 0);
        check({p, "_ctrl_clr"}, ctrl_pend, 0);
        check({p, "_fence_done"}, fence, 1);
        tick();
        check({p, "_done_off"}, done, 0);
        check({p, "_fence_off"}, fence, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        ofunc_dur = 8'd0;
        octrl_dur = 8'd0;
        func_req  = 1'b0;
        ctrl_req  = 1'b0;
        quiesced  = 1'b1;
        err_clear = 1'b0;

        // reset state
        #12;
        check("rst_fence", fence, 0);
        check("rst_reset", afu_reset, 0);
        check("rst_func_pend", func_pend, 0);
        check("rst_ctrl_pend", ctrl_pend, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // 1: control request, octrl dur=3 -> 12 reset cycles
        octrl_dur = 8'd3;
        ofunc_dur = 8'd7;
        ctrl_req = 1'b1;
        tick();
        ctrl_req = 1'b0;
        check("s1_ctrl_pend", ctrl_pend, 1);
        check("s1_func_pend", func_pend, 0);
        run_quiesced_seq("s1", 12);
        tick();

        // 2: function request, dur=0 treated as 1 -> 4 reset cycles
        ofunc_dur = 8'd0;
        octrl_dur = 8'd3;
        func_req = 1'b1;
        tick();
        func_req = 1'b0;
        check("s2_func_pend", func_pend, 1);
        run_quiesced_seq("s2", 4);
        tick();

        // 3: both at once, ofunc=2 octrl=5 -> one sequence of 8 reset cycles
        ofunc_dur = 8'd2;
        octrl_dur = 8'd5;
        func_req = 1'b1;
        ctrl_req = 1'b1;
        tick();
        func_req = 1'b0;
        ctrl_req = 1'b0;
        check("s3_func_pend", func_pend, 1);
        check("s3_ctrl_pend", ctrl_pend, 1);
        run_quiesced_seq("s3", 8);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || fence === 1'b1) dn++;
            tick();
        end
        check("s3_no_second_seq", dn, 0);

        // 4: control request with no quiesce -> timeout after 8 FENCE cycles.
        // A clear that coincides with the timeout edge must lose.
        ofunc_dur = 8'd3;
        octrl_dur = 8'd1;
        quiesced = 1'b0;
        ctrl_req = 1'b1;
        tick();
        ctrl_req = 1'b0;
        tick();
        check("s4_fence", fence, 1);
        n = 0;
        while (afu_reset !== 1'b1 && n < 50) begin
            err_clear = (n == 7);
            tick();
            n++;
        end
        err_clear = 1'b0;
        check("s4_fence_len", n, 8);
        check("s4_timeout_set", timeout, 1);
        // A function request arrives during RESET of the control sequence.
        n = 0;
        while (afu_reset === 1'b1 && n < 50) begin
            func_req = (n == 1);
            n++;
            tick();
        end
        func_req = 1'b0;
        check("s4_ctrl_rst_len", n, 4);
        check("s4_func_pend_mid", func_pend, 1);
        wait_done("s4_done1");
        check("s4_ctrl_clr", ctrl_pend, 0);
        check("s4_func_kept", func_pend, 1);
        quiesced = 1'b1;
        tick();
        check("s4_fence_gap", fence, 0);
        tick();
        check("s4_refence", fence, 1);
        tick();
        check("s4_rst2_on", afu_reset, 1);
        count_reset(n);
        check("s4_func_rst_len", n, 12);
        wait_done("s4_done2");
        check("s4_func_clr", func_pend, 0);
        check("s4_timeout_sticky", timeout, 1);
        tick();
        check("s4_timeout_hold", timeout, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("s4_timeout_clr", timeout, 0);
        tick();

        // 5: async reset in the middle of RESET
        octrl_dur = 8'd3;
        ctrl_req = 1'b1;
        tick();
        ctrl_req = 1'b0;
        tick();
        tick();
        tick();
        check("s5_rst_on", afu_reset, 1);
        #2 reset_n = 1'b0;
        #1;
        check("s5_async_fence", fence, 0);
        check("s5_async_reset", afu_reset, 0);
        check("s5_async_pend", ctrl_pend, 0);
        #2 reset_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fence === 1'b1 || afu_reset === 1'b1 || ctrl_pend === 1'b1) dn++;
        end
        check("s5_idle_after", dn, 0);

        // 6: control request repeated three times during FENCE -> one done
        octrl_dur = 8'd1;
        quiesced = 1'b0;
        ctrl_req = 1'b1;
        tick();
        ctrl_req = 1'b0;
        tick();
        check("s6_fence", fence, 1);
        for (int i = 0; i < 3; i++) begin
            ctrl_req = 1'b1;
            tick();
            ctrl_req = 1'b0;
            tick();
        end
        check("s6_still_fenced", afu_reset, 0);
        quiesced = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dn++;
            tick();
        end
        check("s6_done_count", dn, 1);
        check("s6_ctrl_clr", ctrl_pend, 0);
        check("s6_no_timeout", timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_afu_reset_seq.md
Name: cfg_afu_reset_seq

Overview:
- Sequences function-level and AFU-control-level resets for config function 1.
- Sits between the cfg_func1 register file (reset-request pulses, status readback) and the AFU.
- Consumes the static tieoffs f1_ro_ofunc_reset_duration and f1_ro_octrl00_reset_duration.
- Fences the AFU, waits for quiesce, holds AFU reset for the advertised duration, then releases it and clears the pending status bits.

Parameters:
- TICK_CYCLES, 256, clock cycles per reset-duration unit (range 2..65535).
- QUIESCE_TIMEOUT, 4096, maximum cycles spent in FENCE waiting for afu_cfg_quiesced.
- SETTLE_CYCLES, 16, cycles after reset release before completion is reported (≥1).

Ports:
- clock  in  1  sole clock
- reset_n  in  1  async active-low reset
- f1_ro_ofunc_reset_duration  in  8  function reset duration, in ticks
- f1_ro_octrl00_reset_duration  in  8  AFU-control reset duration, in ticks
- cfg_ofunc_func_reset_req  in  1  1-cycle pulse, function reset written
- cfg_octrl00_afu_reset_req  in  1  1-cycle pulse, AFU control reset written
- afu_cfg_quiesced  in  1  level, AFU has no outstanding commands
- cfg_err_clear  in  1  pulse, clears sticky timeout flag
- cfg_afu_fence  out  1  block new AFU commands
- cfg_afu_reset  out  1  active-high reset to AFU
- cfg_ofunc_reset_pending  out  1  status bit, function reset in progress
- cfg_octrl00_reset_pending  out  1  status bit, control reset in progress
- cfg_reset_done  out  1  1-cycle pulse at sequence completion
- cfg_quiesce_timeout  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Outputs are registered. No combinational path from any input to any output.
- States and transitions:
  - IDLE: when any pending bit is set, go to FENCE next cycle.
  - FENCE: cfg_afu_fence=1.
    - If afu_cfg_quiesced=1, go to RESET next cycle.
    - Otherwise, after QUIESCE_TIMEOUT cycles in FENCE, set cfg_quiesce_timeout and go to RESET anyway.
  - RESET: fence=1, cfg_afu_reset=1.
    - Hold for D*TICK_CYCLES cycles exactly, where D is the duration sampled on FENCE->RESET entry.
    - D=0 is treated as 1.
    - Function reset uses the ofunc duration; otherwise the octrl00 duration is used.
  - RELEASE: fence=1, reset=0. Lasts SETTLE_CYCLES cycles, then go to DONE.
  - DONE: one cycle. cfg_reset_done=1; clear the pending bit(s) being serviced; fence=0 from the next cycle; return to IDLE.
- Request latching: a request pulse sets its pending bit on the next edge, in any state.
- Both requests in the same cycle: both pending bits are set, and a single sequence runs with the function duration.
- Function reset supersedes control reset:
  - Control request during a function sequence: its pending bit is set, then cleared together at DONE.
  - Function request during a control-only sequence: the current sequence finishes. Only octrl00 pending clears at DONE; the FSM then re-enters FENCE for the function reset.
- Repeat request of the same type mid-sequence: absorbed, no extra sequence.
- Timeout flag:
  - Sticky until a cfg_err_clear pulse.
  - If clear and a new timeout occur in the same cycle, set wins.
- Counters: tick prescaler width clog2(TICK_CYCLES); duration counter 8 bits; timeout counter clog2(QUIESCE_TIMEOUT+1). No wrap is reachable.
- Async reset mid-sequence: all outputs drop to 0 immediately; pending requests are lost.
- Duration inputs are static; changes outside FENCE->RESET entry have no effect.

Test Plan (TICK_CYCLES=4, QUIESCE_TIMEOUT=8, SETTLE_CYCLES=2):
- Control request, octrl dur=3, quiesced=1 → fence 1 cycle after pending; reset high exactly 12 cycles; done pulses 2 cycles after release; octrl pending clears with done.
- Function request, dur=0, quiesced=1 → reset high exactly 4 cycles; ofunc pending clears at done.
- Both requests in the same cycle, ofunc=2, octrl=5 → one sequence; reset 8 cycles; both pendings clear on a single done pulse.
- Control request with quiesced=0, function request arriving during RESET → timeout set after 8 FENCE cycles; first sequence completes clearing only octrl pending; second sequence follows with the ofunc duration; timeout stays 1 until a cfg_err_clear pulse.
- reset_n asserted during RESET → fence, reset and pending drop asynchronously; after deassertion, the block is IDLE with no sequence.
- Control request repeated 3 times during FENCE → exactly one done pulse.
